// File: rtl/cache_line_filler.sv
// ============================================================================
// Module   : cache_line_filler
// Purpose  : Cache miss refill engine. It fetches the critical word first,
//            then wraps around the line, and streams each word into the cache.
// Option   : CACHE_FILL_WB_EN adds a write-back of the dirty victim line
//            that runs before the fill.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module cache_line_filler #(
  parameter int DATA_WIDTH   = 8,
  parameter int ADDR_WIDTH   = 8,
  parameter int LINE_WORDS   = 4,
  localparam int OFS_W       = $clog2(LINE_WORDS)
) (
  input  logic                        clk,
  input  logic                        reset,
  input  logic                        req_valid,
  output logic                        req_ready,
  input  logic [ADDR_WIDTH-OFS_W-1:0] req_line_addr,
  input  logic [OFS_W-1:0]            req_word,
`ifdef CACHE_FILL_WB_EN
  input  logic                        req_dirty,
  input  logic [ADDR_WIDTH-OFS_W-1:0] req_victim_line,
  output logic [OFS_W-1:0]            wb_idx,
  input  logic [DATA_WIDTH-1:0]       wb_data,
  output logic                        mem_wr_en,
  output logic [DATA_WIDTH-1:0]       mem_wr_data,
`endif
  output logic                        mem_rd_en,
  output logic [ADDR_WIDTH-1:0]       mem_addr,
  input  logic                        mem_rd_valid,
  input  logic [DATA_WIDTH-1:0]       mem_rd_data,
  output logic                        fill_valid,
  output logic [OFS_W-1:0]            fill_idx,
  output logic [DATA_WIDTH-1:0]       fill_data,
  output logic [ADDR_WIDTH-OFS_W-1:0] fill_line_addr,
  output logic                        fill_crit,
  output logic                        fill_done
);

  localparam int LINE_W = ADDR_WIDTH - OFS_W;
  localparam logic [OFS_W-1:0] c_LAST = OFS_W'(LINE_WORDS - 1);

  typedef enum logic [2:0] {
    IDLE     = 3'd0,
    WB_RD    = 3'd1,
    WB_WR    = 3'd2,
    RD_ISSUE = 3'd3,
    RD_WAIT  = 3'd4,
    DONE     = 3'd5
  } state_t;

  state_t                  state_q, state_d;
  logic [LINE_W-1:0]       line_q, line_d;
  logic [OFS_W-1:0]        idx_q, idx_d;
  logic [OFS_W-1:0]        cnt_q, cnt_d;
  logic                    fill_valid_q, fill_valid_d;
  logic                    fill_crit_q, fill_crit_d;
  logic                    fill_done_q, fill_done_d;
  logic [OFS_W-1:0]        fill_idx_q, fill_idx_d;
  logic [DATA_WIDTH-1:0]   fill_data_q, fill_data_d;
`ifdef CACHE_FILL_WB_EN
  logic [LINE_W-1:0]       victim_q, victim_d;
  logic [OFS_W-1:0]        wb_idx_q, wb_idx_d;
`endif

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q      <= IDLE;
      line_q       <= '0;
      idx_q        <= '0;
      cnt_q        <= '0;
      fill_valid_q <= 1'b0;
      fill_crit_q  <= 1'b0;
      fill_done_q  <= 1'b0;
      fill_idx_q   <= '0;
      fill_data_q  <= '0;
`ifdef CACHE_FILL_WB_EN
      victim_q     <= '0;
      wb_idx_q     <= '0;
`endif
    end else begin
      state_q      <= state_d;
      line_q       <= line_d;
      idx_q        <= idx_d;
      cnt_q        <= cnt_d;
      fill_valid_q <= fill_valid_d;
      fill_crit_q  <= fill_crit_d;
      fill_done_q  <= fill_done_d;
      fill_idx_q   <= fill_idx_d;
      fill_data_q  <= fill_data_d;
`ifdef CACHE_FILL_WB_EN
      victim_q     <= victim_d;
      wb_idx_q     <= wb_idx_d;
`endif
    end
  end

  always_comb begin
    state_d      = state_q;
    line_d       = line_q;
    idx_d        = idx_q;
    cnt_d        = cnt_q;
    fill_valid_d = 1'b0;
    fill_crit_d  = 1'b0;
    fill_done_d  = 1'b0;
    fill_idx_d   = fill_idx_q;
    fill_data_d  = fill_data_q;
    req_ready    = 1'b0;
    mem_rd_en    = 1'b0;
    mem_addr     = '0;
`ifdef CACHE_FILL_WB_EN
    victim_d     = victim_q;
    wb_idx_d     = wb_idx_q;
    mem_wr_en    = 1'b0;
`endif
    case (state_q)
      IDLE: begin
        req_ready = 1'b1;
        if (req_valid) begin
          line_d  = req_line_addr;
          idx_d   = req_word;
          cnt_d   = '0;
          state_d = RD_ISSUE;
`ifdef CACHE_FILL_WB_EN
          victim_d = req_victim_line;
          wb_idx_d = '0;
          if (req_dirty) state_d = WB_RD;
`endif
        end
      end
`ifdef CACHE_FILL_WB_EN
      // WB_RD gives the cache array one cycle to present wb_data for wb_idx.
      WB_RD: state_d = WB_WR;
      WB_WR: begin
        mem_wr_en = 1'b1;
        mem_addr  = {victim_q, wb_idx_q};
        wb_idx_d  = wb_idx_q + 1'b1;
        state_d   = (wb_idx_q == c_LAST) ? RD_ISSUE : WB_RD;
      end
`endif
      RD_ISSUE: begin
        mem_rd_en = 1'b1;
        mem_addr  = {line_q, idx_q};
        state_d   = RD_WAIT;
      end
      RD_WAIT: begin
        mem_addr = {line_q, idx_q};
        if (mem_rd_valid) begin
          fill_valid_d = 1'b1;
          fill_crit_d  = (cnt_q == '0);
          fill_idx_d   = idx_q;
          fill_data_d  = mem_rd_data;
          idx_d        = idx_q + 1'b1;
          cnt_d        = cnt_q + 1'b1;
          state_d      = (cnt_q == c_LAST) ? DONE : RD_ISSUE;
        end
      end
      // fill_done is registered, so it lands in IDLE and overlaps req_ready.
      DONE: begin
        fill_done_d = 1'b1;
        state_d     = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  assign fill_valid     = fill_valid_q;
  assign fill_crit      = fill_crit_q;
  assign fill_done      = fill_done_q;
  assign fill_idx       = fill_idx_q;
  assign fill_data      = fill_data_q;
  assign fill_line_addr = line_q;
`ifdef CACHE_FILL_WB_EN
  assign wb_idx         = wb_idx_q;
  assign mem_wr_data    = wb_data;
`endif

endmodule

`default_nettype wire
